// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter with edge-detected enter/exit events,
// incremental BCD display digits, full/empty decode and sticky error flags.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   enter     - car-entered level from the gate sensor FSM
//   exit      - car-exited level from the gate sensor FSM
//   clr_err   - synchronous clear of ovf_err / unf_err
//   count     - binary occupancy, 0..CAPACITY
//   bcd2/1/0  - occupancy as BCD hundreds / tens / units
//   full      - count == CAPACITY
//   empty     - count == 0
//   ovf_err   - sticky: enter attempted while full
//   unf_err   - sticky: exit attempted while empty
//   upd       - one-cycle pulse in the cycle after count changed
module parking_occupancy_counter #(
    parameter int CAPACITY = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       exit,
    input  logic       clr_err,
    output logic [9:0] count,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       full,
    output logic       empty,
    output logic       ovf_err,
    output logic       unf_err,
    output logic       upd
);

    localparam logic [9:0] CAP = 10'(CAPACITY);

    logic       enter_q;
    logic       exit_q;
    logic       ent_evt;
    logic       ext_evt;
    logic       inc;
    logic       dec;
    logic       ovf_set;
    logic       unf_set;
    logic [3:0] nbcd2;
    logic [3:0] nbcd1;
    logic [3:0] nbcd0;

    // Status decoded from the count register only, so it never
    // follows glitches on the sensor inputs.
    assign full  = (count == CAP);
    assign empty = (count == 10'd0);

    assign ent_evt = enter & ~enter_q;
    assign ext_evt = exit & ~exit_q;

    // Coincident enter and exit events cancel: nothing moves.
    assign inc     = ent_evt & ~ext_evt & (count < CAP);
    assign dec     = ext_evt & ~ent_evt & ~empty;
    assign ovf_set = ent_evt & ~ext_evt & full;
    assign unf_set = ext_evt & ~ent_evt & empty;

    // Decimal ripple: units wrap and carry/borrow into tens, tens into
    // hundreds. Bounded by CAPACITY, so hundreds never exceed 9.
    always_comb begin
        nbcd2 = bcd2;
        nbcd1 = bcd1;
        nbcd0 = bcd0;
        if (inc) begin
            if (bcd0 == 4'd9) begin
                nbcd0 = 4'd0;
                if (bcd1 == 4'd9) begin
                    nbcd1 = 4'd0;
                    nbcd2 = bcd2 + 4'd1;
                end else begin
                    nbcd1 = bcd1 + 4'd1;
                end
            end else begin
                nbcd0 = bcd0 + 4'd1;
            end
        end else if (dec) begin
            if (bcd0 == 4'd0) begin
                nbcd0 = 4'd9;
                if (bcd1 == 4'd0) begin
                    nbcd1 = 4'd9;
                    nbcd2 = bcd2 - 4'd1;
                end else begin
                    nbcd1 = bcd1 - 4'd1;
                end
            end else begin
                nbcd0 = bcd0 - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            count   <= 10'd0;
            bcd2    <= 4'd0;
            bcd1    <= 4'd0;
            bcd0    <= 4'd0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            upd     <= 1'b0;
        end else begin
            enter_q <= enter;
            exit_q  <= exit;
            upd     <= inc | dec;
            if (inc) begin
                count <= count + 10'd1;
            end else if (dec) begin
                count <= count - 10'd1;
            end
            bcd2 <= nbcd2;
            bcd1 <= nbcd1;
            bcd0 <= nbcd0;
            // A new error wins over a simultaneous clear.
            ovf_err <= ovf_set | (ovf_err & ~clr_err);
            unf_err <= unf_set | (unf_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Bench for parking_occupancy_counter: a CAPACITY=50 and a CAPACITY=999
// instance share stimulus; expected outputs are queued and popped per edge.
module tb_parking_occupancy_counter;

    typedef struct packed {
        logic [9:0] cnt;
        logic [3:0] b2;
        logic [3:0] b1;
        logic [3:0] b0;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
        logic       upd;
    } exp_t;

    typedef struct {
        logic       en;
        logic       ex;
        logic       clr;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       upd;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter;
    logic       exit;
    logic       clr_err;

    logic [9:0] count_a, count_b;
    logic [3:0] bcd2_a, bcd1_a, bcd0_a;
    logic [3:0] bcd2_b, bcd1_b, bcd0_b;
    logic       full_a, empty_a, ovf_a, unf_a, upd_a;
    logic       full_b, empty_b, ovf_b, unf_b, upd_b;

    int n_vec = 0;
    int n_bad = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int   cap[2] = '{50, 999};
    int   mc[2];
    logic meq[2];
    logic mxq[2];
    logic movf[2];
    logic munf[2];

    always #5 clk = ~clk;

    parking_occupancy_counter #(.CAPACITY(50)) dut_a (
        .clk(clk), .reset(reset), .enter(enter), .exit(exit),
        .clr_err(clr_err), .count(count_a),
        .bcd2(bcd2_a), .bcd1(bcd1_a), .bcd0(bcd0_a),
        .full(full_a), .empty(empty_a),
        .ovf_err(ovf_a), .unf_err(unf_a), .upd(upd_a)
    );

    parking_occupancy_counter #(.CAPACITY(999)) dut_b (
        .clk(clk), .reset(reset), .enter(enter), .exit(exit),
        .clr_err(clr_err), .count(count_b),
        .bcd2(bcd2_b), .bcd1(bcd1_b), .bcd0(bcd0_b),
        .full(full_b), .empty(empty_b),
        .ovf_err(ovf_b), .unf_err(unf_b), .upd(upd_b)
    );

    function automatic exp_t mk(int c, int cp, logic o, logic u,
                                logic p);
        exp_t e;
        e.cnt   = 10'(c);
        e.b2    = 4'(c / 100);
        e.b1    = 4'((c / 10) % 10);
        e.b0    = 4'(c % 10);
        e.full  = (c == cp);
        e.empty = (c == 0);
        e.ovf   = o;
        e.unf   = u;
        e.upd   = p;
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; meq[i] = 0; mxq[i] = 0;
            movf[i] = 0; munf[i] = 0;
        end
    endfunction

    function automatic exp_t model_step(int i, logic en, logic ex,
                                        logic clr);
        logic ent, ext, so, su, p;
        ent = en && !meq[i];
        ext = ex && !mxq[i];
        so = 0; su = 0; p = 0;
        if (ent && !ext) begin
            if (mc[i] < cap[i]) begin mc[i]++; p = 1; end
            else so = 1;
        end else if (ext && !ent) begin
            if (mc[i] > 0) begin mc[i]--; p = 1; end
            else su = 1;
        end
        movf[i] = so || (movf[i] && !clr);
        munf[i] = su || (munf[i] && !clr);
        meq[i] = en;
        mxq[i] = ex;
        return mk(mc[i], cap[i], movf[i], munf[i], p);
    endfunction

    function automatic exp_t got(int i);
        if (i == 0)
            return '{count_a, bcd2_a, bcd1_a, bcd0_a, full_a, empty_a,
                     ovf_a, unf_a, upd_a};
        return '{count_b, bcd2_b, bcd1_b, bcd0_b, full_b, empty_b,
                 ovf_b, unf_b, upd_b};
    endfunction

    task automatic check_pop(string name);
        exp_t e, g;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            g = got(i);
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s cap=%0d got cnt=%0d bcd=%0d%0d%0d f%b e%b o%b u%b p%b exp cnt=%0d bcd=%0d%0d%0d f%b e%b o%b u%b p%b",
                         name, cap[i], g.cnt, g.b2, g.b1, g.b0, g.full,
                         g.empty, g.ovf, g.unf, g.upd, e.cnt, e.b2, e.b1,
                         e.b0, e.full, e.empty, e.ovf, e.unf, e.upd);
            end
        end
    endtask

    // Drive one cycle; tab_ok selects a hand-written expectation for
    // the CAPACITY=50 instance instead of the model's.
    task automatic apply(string name, logic en, logic ex, logic clr,
                         bit tab_ok, exp_t tab);
        exp_t ea, eb;
        ea = model_step(0, en, ex, clr);
        eb = model_step(1, en, ex, clr);
        q_a.push_back(tab_ok ? tab : ea);
        q_b.push_back(eb);
        enter = en;
        exit = ex;
        clr_err = clr;
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    task automatic step(string name, logic en, logic ex, logic clr);
        apply(name, en, ex, clr, 1'b0, '0);
    endtask

    task automatic pulses(string name, int n);
        for (int k = 0; k < n; k++) begin
            step(name, 1, 0, 0);
            step(name, 0, 0, 0);
        end
    endtask

    task automatic do_reset(string name);
        reset = 1'b1;
        model_reset();
        q_a.push_back(mk(0, 50, 0, 0, 0));
        q_b.push_back(mk(0, 999, 0, 0, 0));
        #2;
        check_pop(name);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tab[24];

    initial begin
        tab[0]  = '{1, 0, 0, 1, 0, 0, 1};
        tab[1]  = '{0, 0, 0, 1, 0, 0, 0};
        tab[2]  = '{1, 0, 0, 2, 0, 0, 1};
        tab[3]  = '{0, 0, 0, 2, 0, 0, 0};
        tab[4]  = '{1, 0, 0, 3, 0, 0, 1};
        tab[5]  = '{1, 0, 0, 3, 0, 0, 0};
        tab[6]  = '{1, 0, 0, 3, 0, 0, 0};
        tab[7]  = '{0, 0, 0, 3, 0, 0, 0};
        tab[8]  = '{0, 1, 0, 2, 0, 0, 1};
        tab[9]  = '{0, 0, 0, 2, 0, 0, 0};
        tab[10] = '{1, 1, 0, 2, 0, 0, 0};
        tab[11] = '{0, 0, 0, 2, 0, 0, 0};
        tab[12] = '{0, 1, 0, 1, 0, 0, 1};
        tab[13] = '{1, 1, 0, 2, 0, 0, 1};
        tab[14] = '{0, 0, 0, 2, 0, 0, 0};
        tab[15] = '{0, 1, 0, 1, 0, 0, 1};
        tab[16] = '{0, 0, 0, 1, 0, 0, 0};
        tab[17] = '{0, 1, 0, 0, 0, 0, 1};
        tab[18] = '{0, 0, 0, 0, 0, 0, 0};
        tab[19] = '{0, 1, 0, 0, 0, 1, 0};
        tab[20] = '{0, 0, 0, 0, 0, 1, 0};
        tab[21] = '{0, 1, 1, 0, 0, 1, 0};
        tab[22] = '{0, 0, 1, 0, 0, 0, 0};
        tab[23] = '{0, 0, 0, 0, 0, 0, 0};

        enter = 0;
        exit = 0;
        clr_err = 0;
        reset = 0;
        #1;
        do_reset("reset");

        for (int k = 0; k < 24; k++)
            apply("table", tab[k].en, tab[k].ex, tab[k].clr, 1'b1,
                  mk(tab[k].cnt, 50, tab[k].ovf, tab[k].unf,
                     tab[k].upd));

        for (int k = 0; k < 10; k++) step("hold10", 1, 0, 0);
        step("hold10", 0, 0, 0);

        pulses("fill", 49);
        pulses("overflow", 1);
        step("clr_ovf", 0, 0, 1);
        step("after_clr", 0, 0, 0);
        step("same5", 1, 1, 0);

        pulses("to98", 47);
        pulses("to101", 3);
        for (int k = 0; k < 2; k++) begin
            step("to99", 0, 1, 0);
            step("to99", 0, 0, 0);
        end

        do_reset("reset2");
        pulses("to7", 7);

        enter = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        q_a.push_back(mk(0, 50, 0, 0, 0));
        q_b.push_back(mk(0, 999, 0, 0, 0));
        #1;
        check_pop("async_rst");
        #2;
        reset = 1'b0;
        step("first_edge", 1, 0, 0);
        step("first_edge", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_counter.md
PARKING_OCCUPANCY_COUNTER -- requirements
Module: parking_occupancy_counter

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 50, giving the maximum lot occupancy; the legal range is 1..999.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous, active-high reset.
REQ-004 The block SHALL have port enter, input, 1 bit, the car-entered indication from the gate sensor FSM.
REQ-005 The block SHALL have port exit, input, 1 bit, the car-exited indication from the gate sensor FSM.
REQ-006 The block SHALL have port clr_err, input, 1 bit, a synchronous clear of the sticky error flags.
REQ-007 The block SHALL have port count, output, 10 bits, the binary occupancy.
REQ-008 The block SHALL have ports bcd2, bcd1 and bcd0, output, 4 bits each, giving the occupancy as BCD hundreds, tens and units.
REQ-009 The block SHALL have port full, output, 1 bit, high when count equals CAPACITY.
REQ-010 The block SHALL have port empty, output, 1 bit, high when count equals 0.
REQ-011 The block SHALL have port ovf_err, output, 1 bit, a sticky flag for an enter attempt while full.
REQ-012 The block SHALL have port unf_err, output, 1 bit, a sticky flag for an exit attempt while empty.
REQ-013 The block SHALL have port upd, output, 1 bit, a one-cycle pulse on the cycle after count changes.

Function
REQ-014 The block SHALL register enter and exit each cycle into enter_q and exit_q.
REQ-015 The block SHALL define ent_evt = enter AND NOT enter_q, and ext_evt = exit AND NOT exit_q; a level held high for N cycles yields one event.
REQ-016 On an ent_evt edge with ext_evt low and count < CAPACITY, count SHALL increment by 1, visible immediately after that clock edge (latency 1 clock from input assertion).
REQ-017 On an ext_evt edge with ent_evt low and count > 0, count SHALL decrement by 1 with the same latency.
REQ-018 When ent_evt and ext_evt occur in the same cycle, count, BCD digits and error flags SHALL be unchanged and upd SHALL NOT pulse.
REQ-019 An ent_evt alone at count == CAPACITY SHALL hold count and set ovf_err.
REQ-020 An ext_evt alone at count == 0 SHALL hold count and set unf_err.
REQ-021 ovf_err and unf_err SHALL remain set until clr_err is sampled high.
REQ-022 If clr_err is high in the same cycle a new error occurs, set SHALL take priority and the flag SHALL end the cycle high.
REQ-023 The BCD digits SHALL be maintained incrementally, in lockstep with count, on the same edge; no binary-to-BCD converter is used.
REQ-024 On increment the BCD digits SHALL wrap 9->0 with a carry to the next digit.
REQ-025 On decrement the BCD digits SHALL wrap 0->9 with a borrow from the next digit.
REQ-026 The BCD value SHALL always equal count, e.g. count 100 gives bcd2/bcd1/bcd0 = 1/0/0, and 99->100->99 SHALL round-trip.
REQ-027 full and empty SHALL be decoded from the count register only (glitch-free with respect to the inputs).
REQ-028 upd SHALL be a registered pulse, high for exactly one cycle following each count change, and low otherwise.
REQ-029 count SHALL never exceed CAPACITY and SHALL never wrap below 0.

Reset
REQ-030 Asserting reset SHALL immediately drive to 0: count, bcd2/bcd1/bcd0, ovf_err, unf_err, upd, enter_q and exit_q. As a result empty=1 and full=0.
REQ-031 A reset asserted mid-operation SHALL discard any event in flight.
REQ-032 After reset release, enter or exit sampled high at the first rising edge SHALL count as an event, because the edge registers are 0.

Verification
REQ-033 Scenario: reset, then 3 single-cycle enter pulses -> count=3, bcd=0/0/3, upd pulsed 3 times, empty=0.
REQ-034 Scenario: enter held high for 10 cycles -> count increments by exactly 1.
REQ-035 Scenario: CAPACITY=50, 50 enters then 1 more -> count=50, full=1, ovf_err=1; clr_err pulse -> ovf_err=0 and count stays 50.
REQ-036 Scenario: from empty, an exit pulse -> count=0, unf_err=1, upd stays 0; a later exit coinciding with clr_err -> unf_err remains 1.
REQ-037 Scenario: count=5, enter and exit rising in the same cycle -> count=5, no upd, no error.
REQ-038 Scenario: CAPACITY=999, drive count 98->101->99 -> BCD tracks 0/9/8, 0/9/9, 1/0/0, 1/0/1, 1/0/0, 0/9/9.
REQ-039 Scenario: async reset pulse between clock edges at count=7 -> all outputs clear before the next edge.
